// File: rtl/vga_rgb_source.sv
// VGA timing generator and RGB test-pattern source.
// Optional macro: VGA_RGB_SOURCE_FRAME_COUNTER_EN (scrolling patterns).
module vga_rgb_source #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic [7:0] dr,
  output logic [7:0] dg,
  output logic [7:0] db
);

  localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_VIS);
  localparam logic [9:0] V_ACT  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

  logic [9:0] h;
  logic [9:0] v;
  logic [1:0] mode_q;
  logic       run;
  logic       h_last;
  logic       wrap;
  logic       vis_n;
  logic       hs_n;
  logic       vs_n;
  logic [2:0] idx;
  logic [7:0] grad_r;
  logic [7:0] chk;
  logic [7:0] r_n;
  logic [7:0] g_n;
  logic [7:0] b_n;

`ifdef VGA_RGB_SOURCE_FRAME_COUNTER_EN
  logic [7:0] frame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame <= '0;
    end else if (run && wrap) begin
      frame <= frame + 8'd1;
    end
  end

  assign grad_r = h[7:0] + frame;
  assign idx    = h[8:6] + frame[7:5];
`else
  assign grad_r = h[7:0];
  assign idx    = h[8:6];
`endif

  assign h_last = (h == H_LAST);
  assign wrap   = h_last && (v == V_LAST);
  assign vis_n  = (h < H_ACT) && (v < V_ACT);
  assign hs_n   = !((h >= HS_BEG) && (h < HS_END));
  assign vs_n   = !((v >= VS_BEG) && (v < VS_END));
  assign chk    = {8{h[5] ^ v[5]}};

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (vis_n) begin
      unique case (mode_q)
        2'd0: begin
          r_n = grad_r;
          g_n = v[7:0];
          b_n = h[7:0] ^ v[7:0];
        end
        2'd1: begin
          r_n = 8'hFF;
          g_n = 8'hFF;
          b_n = 8'hFF;
        end
        2'd2: begin
          r_n = {8{idx[2]}};
          g_n = {8{idx[1]}};
          b_n = {8{idx[0]}};
        end
        default: begin
          r_n = chk;
          g_n = chk;
          b_n = chk;
        end
      endcase
    end
  end

  // First edge after reset only (re)enters frame start; outputs follow one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run     <= 1'b0;
      h       <= '0;
      v       <= '0;
      mode_q  <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      visible <= 1'b0;
      hpos    <= '0;
      vpos    <= '0;
      dr      <= '0;
      dg      <= '0;
      db      <= '0;
    end else if (!run) begin
      run    <= 1'b1;
      h      <= '0;
      v      <= '0;
      mode_q <= mode;
    end else begin
      h <= h_last ? '0 : h + 10'd1;
      if (h_last) begin
        v <= (v == V_LAST) ? '0 : v + 10'd1;
      end
      if (wrap) begin
        mode_q <= mode;
      end
      hsync   <= hs_n;
      vsync   <= vs_n;
      visible <= vis_n;
      hpos    <= h;
      vpos    <= v;
      dr      <= r_n;
      dg      <= g_n;
      db      <= b_n;
    end
  end

endmodule

// File: doc/vga_rgb_source.md
Name: vga_rgb_source

Overview:
- Timing generator and pixel-pattern source for the 24-bit RGB path.
- Produces the dr/dg/db digital colour words that feed the per-channel output buffers and DACs, plus hsync/vsync/visible.
- Registered single-clock design; the default parameters give 640x480 @ 60 Hz timing from a 25.175 MHz pixel clock.
- Used for bring-up and as the default picture source when no external pixel data is present.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_VIS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  input  1  pixel clock, rising edge
reset  input  1  asynchronous, active-high reset
mode  input  2  pattern select; sampled only at frame start
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
visible  output  1  high when the current pixel is in the active area
hpos  output  10  horizontal position of the current output pixel
vpos  output  10  vertical position of the current output pixel
dr  output  8  red pixel word
dg  output  8  green pixel word
db  output  8  blue pixel word

Behaviour:
- Reset values (asynchronous): h=0, v=0, mode_q=0, hsync=1, vsync=1, visible=0, hpos=0, vpos=0, dr=dg=db=0.
- Counter h runs 0..H_TOT-1, where H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 800.
- When h = H_TOT-1, h wraps to 0 and v advances.
- Counter v runs 0..V_TOT-1, where V_TOT = V_VIS+V_FP+V_SYNC+V_BP = 525, and wraps to 0 after V_TOT-1.
- Frame start is h=0, v=0. On the clock edge where the counters move to (0,0), mode_q <= mode. Changing mode mid-frame has no effect until the next frame.
- All outputs are registered and reflect the counter values of the previous cycle: 1 clock of latency from (h,v) to the outputs. hpos, vpos, sync and rgb are mutually aligned.
- hsync = 0 iff H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC (656..751 at default parameters).
- vsync = 0 iff V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC (490..491 at default parameters). vsync is line-granular: it changes on the same edge that h wraps.
- visible = (h < H_VIS) && (v < V_VIS).
- When visible = 0, dr = dg = db = 0x00 (mandatory blanking for the DAC).
- When visible = 1, the pixel is selected by mode_q:
  - 0, gradient: dr = h[7:0], dg = v[7:0], db = (h ^ v)[7:0].
  - 1, solid white: all channels 0xFF.
  - 2, colour bars of 64 px: idx = h[8:6]; dr = {8{idx[2]}}, dg = {8{idx[1]}}, db = {8{idx[0]}}.
  - 3, checkerboard of 32 px: all channels = {8{h[5]^v[5]}}.
- All arithmetic is modulo 2^8 on the truncated position bits. There is no saturation.
- Reset asserted mid-frame: outputs return to their reset values immediately (asynchronously). After reset deasserts, the counters restart at (0,0) on the next edge.

Optional Feature:
- Macro: VGA_RGB_SOURCE_FRAME_COUNTER_EN.
- When defined:
  - An internal 8-bit frame counter resets to 0.
  - It increments (wrapping 255->0) on the edge where the counters move from (H_TOT-1, V_TOT-1) to (0,0).
  - Mode 0 uses dr = h[7:0] + frame, which scrolls the red gradient one pixel per frame.
  - Mode 2 uses idx = h[8:6] + frame[7:5].
- When undefined: no counter exists and modes 0 and 2 are exactly as specified in Behaviour.
- Sync, visible and the other modes are identical in both builds.

Test Plan:
- Reset held then released:
  - During reset: hsync=1, vsync=1, rgb=0.
  - First edge after release: counters at (0,0).
  - Second edge: visible=1, hpos=0, vpos=0.
- Free-run one line:
  - hsync falls with output hpos=656, stays low for 96 clocks, rises at hpos=752.
  - Line period is 800 clocks.
- Free-run one frame:
  - vsync is low exactly for lines 490 and 491.
  - Frame period is 420000 clocks.
  - visible is high for 307200 clocks per frame.
- mode=0:
  - At hpos=300, vpos=200: dr=0x2C, dg=0xC8, db=0xE4.
  - At hpos=650: rgb=0 (blanked).
- mode=2:
  - At hpos=64..127: dr=00, dg=00, db=FF.
  - At hpos=448: dr=FF, dg=FF, db=FF.
- mode switched from 1 to 3 at line 100:
  - The rest of that frame stays white.
  - The next frame shows a checkerboard: (hpos=32, vpos=0) gives 0xFF; (32,32) gives 0x00.
  - With VGA_RGB_SOURCE_FRAME_COUNTER_EN, mode 0 frame 2 at hpos=10 gives dr=0x0C.
